// File: rtl/pc_seq_ctl.sv
// Program-counter sequencer: INIT/RUN/HALTED control, conditional branches, jumps,
// and a one-entry pending redirect held across stalls. Define PC_TAKEN_CNT_EN to build the redirect counter.
module pc_seq_ctl #(
    parameter int unsigned     PC_W     = 16,
    parameter int unsigned     PC_INC   = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            halt,
    input  logic            br_valid,
    input  logic [1:0]      br_cond,
    input  logic            zero,
    input  logic            alu_msb,
    input  logic            jump,
    input  logic            jump_reg,
    input  logic [PC_W-1:0] br_target,
    input  logic [PC_W-1:0] jr_target,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus,
    output logic            flush,
    output logic            halted,
    output logic [15:0]     taken_cnt
);

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [PC_W-1:0] pc_nx;
    logic            pend_valid, pend_valid_nx;
    logic [PC_W-1:0] pend_target, pend_target_nx;
    logic            flush_nx;
    logic            cond_true;
    logic            taken;
    logic [PC_W-1:0] target;
    logic            redirect;

    assign pc_plus = pc + PC_W'(PC_INC);
    assign halted  = (state == HALTED);

    always_comb begin
        cond_true = 1'b0;
        case (br_cond)
            2'b00:   cond_true = zero;
            2'b01:   cond_true = ~zero;
            2'b10:   cond_true = alu_msb;
            default: cond_true = ~alu_msb;
        endcase
    end

    // A jump overrides any branch, so it alone picks between the two target ports.
    assign taken  = jump | (br_valid & cond_true);
    assign target = (jump & jump_reg) ? jr_target : br_target;

    always_comb begin
        state_nx       = state;
        pc_nx          = pc;
        pend_valid_nx  = pend_valid;
        pend_target_nx = pend_target;
        redirect       = 1'b0;
        case (state)
            INIT: begin
                state_nx      = RUN;
                pc_nx         = RESET_PC;
                pend_valid_nx = 1'b0;
            end
            RUN: begin
                if (halt) begin
                    state_nx      = HALTED;
                    pend_valid_nx = 1'b0;
                end else if (stall) begin
                    if (taken) begin
                        pend_valid_nx  = 1'b1;
                        pend_target_nx = target;
                    end
                end else if (taken) begin
                    // A fresh redirect supersedes whatever was left pending.
                    pc_nx         = target;
                    pend_valid_nx = 1'b0;
                    redirect      = 1'b1;
                end else if (pend_valid) begin
                    pc_nx         = pend_target;
                    pend_valid_nx = 1'b0;
                    redirect      = 1'b1;
                end else begin
                    pc_nx = pc_plus;
                end
            end
            HALTED: begin
                state_nx = HALTED;
            end
            default: begin
                state_nx      = INIT;
                pc_nx         = RESET_PC;
                pend_valid_nx = 1'b0;
            end
        endcase
        flush_nx = redirect;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= INIT;
            pc          <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            flush       <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            pend_valid  <= pend_valid_nx;
            pend_target <= pend_target_nx;
            flush       <= flush_nx;
        end
    end

`ifdef PC_TAKEN_CNT_EN
    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (redirect && (cnt != '1)) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign taken_cnt = cnt;
`else
    assign taken_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_seq_ctl.sv
// Directed table-driven bench for pc_seq_ctl, plus hand sequences for wrap-around
// and reset during a pending redirect.
module tb_pc_seq_ctl;

`ifdef PC_TAKEN_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, halt, br_valid, zero, alu_msb, jump, jump_reg;
    logic [1:0]  br_cond;
    logic [15:0] br_target, jr_target;
    logic [15:0] pc, pc_plus, taken_cnt;
    logic        flush, halted;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    pc_seq_ctl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .halt      (halt),
        .br_valid  (br_valid),
        .br_cond   (br_cond),
        .zero      (zero),
        .alu_msb   (alu_msb),
        .jump      (jump),
        .jump_reg  (jump_reg),
        .br_target (br_target),
        .jr_target (jr_target),
        .pc        (pc),
        .pc_plus   (pc_plus),
        .flush     (flush),
        .halted    (halted),
        .taken_cnt (taken_cnt)
    );

    typedef struct {
        logic        stall, halt, br_valid;
        logic [1:0]  br_cond;
        logic        zero, alu_msb, jump, jump_reg;
        logic [15:0] br_target, jr_target;
        logic [15:0] exp_pc;
        logic        exp_flush, exp_halted;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[28];

    function automatic vec_t mk(logic s, logic h, logic bv, logic [1:0] bc, logic z, logic m,
                                logic j, logic jr, logic [15:0] bt, logic [15:0] jt,
                                logic [15:0] epc, logic ef, logic eh, logic [15:0] ec);
        vec_t v;
        v.stall = s; v.halt = h; v.br_valid = bv; v.br_cond = bc; v.zero = z; v.alu_msb = m;
        v.jump = j; v.jump_reg = jr; v.br_target = bt; v.jr_target = jt;
        v.exp_pc = epc; v.exp_flush = ef; v.exp_halted = eh;
        v.exp_cnt = CNT_EN ? ec : 16'd0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        stall = 0; halt = 0; br_valid = 0; br_cond = 2'b00; zero = 0; alu_msb = 0;
        jump = 0; jump_reg = 0; br_target = '0; jr_target = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // s  h  bv cond  z  m  j  jr  br_tgt    jr_tgt    exp_pc    f  h  cnt
        vecs[0]  = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0002, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0004, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 2'b00, 0, 0, 1, 0, 16'h0010, 16'h0000, 16'h0010, 1, 0, 1);
        vecs[4]  = mk(0, 0, 1, 2'b10, 0, 1, 0, 0, 16'h0040, 16'h0000, 16'h0040, 1, 0, 2);
        vecs[5]  = mk(0, 0, 1, 2'b10, 0, 0, 0, 0, 16'h0070, 16'h0000, 16'h0042, 0, 0, 2);
        vecs[6]  = mk(0, 0, 1, 2'b01, 0, 0, 0, 0, 16'h0080, 16'h0000, 16'h0080, 1, 0, 3);
        vecs[7]  = mk(0, 0, 1, 2'b01, 1, 0, 0, 0, 16'h00F0, 16'h0000, 16'h0082, 0, 0, 3);
        vecs[8]  = mk(0, 0, 1, 2'b11, 0, 0, 0, 0, 16'h0090, 16'h0000, 16'h0090, 1, 0, 4);
        vecs[9]  = mk(0, 0, 1, 2'b11, 0, 1, 0, 0, 16'h00F0, 16'h0000, 16'h0092, 0, 0, 4);
        vecs[10] = mk(0, 0, 1, 2'b00, 0, 0, 0, 0, 16'h00F0, 16'h0000, 16'h0094, 0, 0, 4);
        vecs[11] = mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0094, 0, 0, 4);
        vecs[12] = mk(1, 0, 0, 2'b00, 0, 0, 1, 1, 16'h0000, 16'h0100, 16'h0094, 0, 0, 4);
        vecs[13] = mk(1, 0, 0, 2'b00, 0, 0, 1, 1, 16'h0000, 16'h0100, 16'h0094, 0, 0, 4);
        vecs[14] = mk(1, 0, 0, 2'b00, 0, 0, 1, 1, 16'h0000, 16'h0100, 16'h0094, 0, 0, 4);
        vecs[15] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0100, 1, 0, 5);
        vecs[16] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0102, 0, 0, 5);
        vecs[17] = mk(0, 0, 1, 2'b00, 1, 0, 1, 1, 16'h0250, 16'h0300, 16'h0300, 1, 0, 6);
        vecs[18] = mk(1, 0, 0, 2'b00, 0, 0, 1, 0, 16'h0200, 16'h0000, 16'h0300, 0, 0, 6);
        vecs[19] = mk(1, 0, 1, 2'b00, 1, 0, 0, 0, 16'h0280, 16'h0000, 16'h0300, 0, 0, 6);
        vecs[20] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0280, 1, 0, 7);
        vecs[21] = mk(1, 0, 0, 2'b00, 0, 0, 1, 0, 16'h0200, 16'h0000, 16'h0280, 0, 0, 7);
        vecs[22] = mk(0, 0, 1, 2'b00, 1, 0, 0, 0, 16'h0300, 16'h0000, 16'h0300, 1, 0, 8);
        vecs[23] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0302, 0, 0, 8);
        vecs[24] = mk(1, 0, 0, 2'b00, 0, 0, 1, 1, 16'h0000, 16'h0400, 16'h0302, 0, 0, 8);
        vecs[25] = mk(0, 1, 0, 2'b00, 0, 0, 1, 0, 16'h0500, 16'h0000, 16'h0302, 0, 1, 8);
        vecs[26] = mk(0, 0, 0, 2'b00, 0, 0, 1, 0, 16'h0600, 16'h0000, 16'h0302, 0, 1, 8);
        vecs[27] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0302, 0, 1, 8);

        idle();
        rst_n = 0;
        tick();
        tick();
        chk("reset pc", pc, 16'h0000);
        chk("reset flush", {15'd0, flush}, 16'd0);
        chk("reset halted", {15'd0, halted}, 16'd0);
        chk("reset cnt", taken_cnt, 16'd0);
        rst_n = 1;

        for (int i = 0; i < 28; i++) begin
            stall = vecs[i].stall; halt = vecs[i].halt; br_valid = vecs[i].br_valid;
            br_cond = vecs[i].br_cond; zero = vecs[i].zero; alu_msb = vecs[i].alu_msb;
            jump = vecs[i].jump; jump_reg = vecs[i].jump_reg;
            br_target = vecs[i].br_target; jr_target = vecs[i].jr_target;
            tick();
            chk($sformatf("v%0d pc", i), pc, vecs[i].exp_pc);
            chk($sformatf("v%0d pc_plus", i), pc_plus, vecs[i].exp_pc + 16'd2);
            chk($sformatf("v%0d flush", i), {15'd0, flush}, {15'd0, vecs[i].exp_flush});
            chk($sformatf("v%0d halted", i), {15'd0, halted}, {15'd0, vecs[i].exp_halted});
            chk($sformatf("v%0d cnt", i), taken_cnt, vecs[i].exp_cnt);
        end

        // Leave HALTED via reset, then wrap the PC past 0xFFFE.
        idle();
        rst_n = 0;
        tick();
        chk("halt reset halted", {15'd0, halted}, 16'd0);
        chk("halt reset cnt", taken_cnt, 16'd0);
        rst_n = 1;
        tick();
        chk("post-reset init pc", pc, 16'h0000);
        jump = 1; br_target = 16'hFFFE;
        tick();
        chk("wrap setup pc", pc, 16'hFFFE);
        chk("wrap pc_plus", pc_plus, 16'h0000);
        idle();
        tick();
        chk("wrap pc", pc, 16'h0000);
        chk("wrap flush", {15'd0, flush}, 16'd0);
        tick();
        chk("wrap next pc", pc, 16'h0002);

        // Reset while a redirect is pending must drop it.
        stall = 1; jump = 1; jump_reg = 1; jr_target = 16'h0700;
        tick();
        chk("pend hold pc", pc, 16'h0002);
        rst_n = 0;
        tick();
        chk("pend reset pc", pc, 16'h0000);
        idle();
        rst_n = 1;
        tick();
        chk("pend init pc", pc, 16'h0000);
        tick();
        chk("pend dropped pc", pc, 16'h0002);
        chk("pend dropped flush", {15'd0, flush}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
